// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - IF/IE interrupt flag and enable registers; optional INT_EDGE_DETECT_EN
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic        clk4_2,
  input  logic        reset,
  input  logic [15:0] address_bus,
  input  logic [7:0]  data_bus_in,
  input  logic        mem_we,
  output logic [7:0]  data_bus_out,
  output logic        rd_sel,
  input  logic        v_blank_int_src,
  input  logic        lcd_stat_int_src,
  input  logic        timer_int_src,
  input  logic        serial_int_src,
  input  logic        joypad_int_src,
  input  logic        cpu_v_blank_int_clear,
  input  logic        cpu_lcd_stat_int_clear,
  input  logic        cpu_timer_int_clear,
  input  logic        cpu_serial_int_clear,
  input  logic        cpu_joypad_int_clear,
  output logic        v_blank_int_req,
  output logic        lcd_stat_int_req,
  output logic        timer_int_req,
  output logic        serial_int_req,
  output logic        joypad_int_req,
  output logic        int_pending,
  output logic [2:0]  int_id
);

  logic [4:0] src;
  logic [4:0] clr;
  logic [4:0] ev;
  logic [4:0] if_q, if_d;
  logic [7:0] ie_q, ie_d;
  logic [4:0] req;
  logic       if_hit;
  logic       ie_hit;

  assign src = {joypad_int_src, serial_int_src, timer_int_src, lcd_stat_int_src, v_blank_int_src};
  assign clr = {cpu_joypad_int_clear, cpu_serial_int_clear, cpu_timer_int_clear,
                cpu_lcd_stat_int_clear, cpu_v_blank_int_clear};

  assign if_hit = (address_bus == IF_ADDR);
  assign ie_hit = (address_bus == IE_ADDR);

`ifdef INT_EDGE_DETECT_EN
  logic [4:0] src_q;

  // Remember last source level so only a low-to-high transition raises a flag
  always_ff @(posedge clk4_2 or posedge reset) begin
    if (reset) begin
      src_q <= 5'd0;
    end else begin
      src_q <= src;
    end
  end

  assign ev = src & ~src_q;
`else
  assign ev = src;
`endif

  // Flag update: new event beats CPU write, which beats acknowledge
  always_comb begin
    if_d = if_q;
    for (int n = 0; n < 5; n++) begin
      if (ev[n]) begin
        if_d[n] = 1'b1;
      end else if (mem_we && if_hit) begin
        if_d[n] = data_bus_in[n];
      end else if (clr[n]) begin
        if_d[n] = 1'b0;
      end
    end
  end

  // Enable mask keeps all eight bits so software reads back what it wrote
  always_comb begin
    ie_d = ie_q;
    if (mem_we && ie_hit) begin
      ie_d = data_bus_in;
    end
  end

  // Register state; reset drops all pending flags without waiting for a clock
  always_ff @(posedge clk4_2 or posedge reset) begin
    if (reset) begin
      if_q <= 5'd0;
      ie_q <= 8'd0;
    end else begin
      if_q <= if_d;
      ie_q <= ie_d;
    end
  end

  // Zero-wait-state read mux; unused IF bits read as ones
  always_comb begin
    data_bus_out = 8'h00;
    rd_sel       = 1'b0;
    if (!mem_we) begin
      if (if_hit) begin
        data_bus_out = {3'b111, if_q};
        rd_sel       = 1'b1;
      end else if (ie_hit) begin
        data_bus_out = ie_q;
        rd_sel       = 1'b1;
      end
    end
  end

  assign req              = if_q & ie_q[4:0];
  assign v_blank_int_req  = req[0];
  assign lcd_stat_int_req = req[1];
  assign timer_int_req    = req[2];
  assign serial_int_req   = req[3];
  assign joypad_int_req   = req[4];
  assign int_pending      = |req;

  // Fixed priority encoder, lowest bit wins; 7 means nothing pending
  always_comb begin
    int_id = 3'd7;
    if (req[0]) begin
      int_id = 3'd0;
    end else if (req[1]) begin
      int_id = 3'd1;
    end else if (req[2]) begin
      int_id = 3'd2;
    end else if (req[3]) begin
      int_id = 3'd3;
    end else if (req[4]) begin
      int_id = 3'd4;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller
module tb_interrupt_controller;

  localparam logic [15:0] IF_A = 16'hFF0F;
  localparam logic [15:0] IE_A = 16'hFFFF;

  localparam int K_IF    = 0;
  localparam int K_IE    = 1;
  localparam int K_REQ   = 2;
  localparam int K_ID    = 3;
  localparam int K_PEND  = 4;
  localparam int K_OTHER = 5;
  localparam int K_WRSEL = 6;

  typedef struct {
    int         kind;
    logic [8:0] exp;
    string      tag;
  } exp_t;

  logic        clk4_2 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_bus = 16'h0000;
  logic [7:0]  data_bus_in = 8'h00;
  logic        mem_we = 1'b0;
  logic [7:0]  data_bus_out;
  logic        rd_sel;
  logic [4:0]  src = 5'd0;
  logic [4:0]  clr = 5'd0;
  logic [4:0]  req;
  logic        int_pending;
  logic [2:0]  int_id;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  interrupt_controller dut (
    .clk4_2                 (clk4_2),
    .reset                  (reset),
    .address_bus            (address_bus),
    .data_bus_in            (data_bus_in),
    .mem_we                 (mem_we),
    .data_bus_out           (data_bus_out),
    .rd_sel                 (rd_sel),
    .v_blank_int_src        (src[0]),
    .lcd_stat_int_src       (src[1]),
    .timer_int_src          (src[2]),
    .serial_int_src         (src[3]),
    .joypad_int_src         (src[4]),
    .cpu_v_blank_int_clear  (clr[0]),
    .cpu_lcd_stat_int_clear (clr[1]),
    .cpu_timer_int_clear    (clr[2]),
    .cpu_serial_int_clear   (clr[3]),
    .cpu_joypad_int_clear   (clr[4]),
    .v_blank_int_req        (req[0]),
    .lcd_stat_int_req       (req[1]),
    .timer_int_req          (req[2]),
    .serial_int_req         (req[3]),
    .joypad_int_req         (req[4]),
    .int_pending            (int_pending),
    .int_id                 (int_id)
  );

  always #5 clk4_2 = ~clk4_2;

  task automatic check_eq(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [8:0] exp, input string tag);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic exp_if(input logic [7:0] v, input string tag);
    push(K_IF, {1'b1, v}, tag);
  endtask

  task automatic exp_state(input logic [4:0] r, input logic [2:0] id, input string tag);
    push(K_REQ, {4'd0, r}, {tag, "_req"});
    push(K_ID, {6'd0, id}, {tag, "_id"});
    push(K_PEND, {8'd0, |r}, {tag, "_pend"});
  endtask

  task automatic step();
    @(posedge clk4_2);
    #1;
  endtask

  // Observe the DUT between clock edges and compare against queued expectations
  task automatic drain();
    exp_t        e;
    logic [15:0] sa;
    logic        sw;
    logic [8:0]  obs;
    sa = address_bus;
    sw = mem_we;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = 9'd0;
      case (e.kind)
        K_IF: begin
          address_bus = IF_A; mem_we = 1'b0; #1;
          obs = {rd_sel, data_bus_out};
        end
        K_IE: begin
          address_bus = IE_A; mem_we = 1'b0; #1;
          obs = {rd_sel, data_bus_out};
        end
        K_OTHER: begin
          address_bus = 16'h1234; mem_we = 1'b0; #1;
          obs = {rd_sel, data_bus_out};
        end
        K_WRSEL: begin
          address_bus = IF_A; mem_we = 1'b1; #1;
          obs = {rd_sel, data_bus_out};
          mem_we = 1'b0;
        end
        K_REQ:  obs = {4'd0, req};
        K_ID:   obs = {6'd0, int_id};
        K_PEND: obs = {8'd0, int_pending};
        default: obs = 9'h1FF;
      endcase
      check_eq(e.tag, obs, e.exp);
    end
    address_bus = sa;
    mem_we = sw;
    #1;
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    address_bus = a;
    data_bus_in = d;
    mem_we = 1'b1;
    step();
    mem_we = 1'b0;
    address_bus = 16'h0000;
    data_bus_in = 8'h00;
  endtask

  task automatic pulse_src(input logic [4:0] s);
    src = s;
    step();
    src = 5'd0;
  endtask

  task automatic pulse_clr(input logic [4:0] c);
    clr = c;
    step();
    clr = 5'd0;
  endtask

  initial begin
    // 1: reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    exp_if(8'hE0, "rst_if");
    push(K_IE, {1'b1, 8'h00}, "rst_ie");
    exp_state(5'd0, 3'd7, "rst");
    push(K_OTHER, 9'h000, "unmapped_read");
    push(K_WRSEL, 9'h000, "rdsel_on_write");
    drain();

    // 2: single timer pulse
    write_reg(IE_A, 8'h1F);
    pulse_src(5'b00100);
    exp_state(5'b00100, 3'd2, "timer");
    exp_if(8'hE4, "timer_if");
    drain();
    pulse_clr(5'b00100);
    exp_if(8'hE0, "timer_clr_if");
    exp_state(5'd0, 3'd7, "timer_clr");
    drain();

    // 3: v_blank and joypad together, then ack v_blank
    pulse_src(5'b10001);
    exp_state(5'b10001, 3'd0, "vb_joy");
    drain();
    pulse_clr(5'b00001);
    exp_state(5'b10000, 3'd4, "vb_ack");
    exp_if(8'hF0, "vb_ack_if");
    drain();
    pulse_clr(5'b10000);
    exp_if(8'hE0, "joy_ack_if");
    drain();

    // 4: masked serial, then enable it
    write_reg(IE_A, 8'h00);
    pulse_src(5'b01000);
    exp_if(8'hE8, "ser_masked_if");
    exp_state(5'd0, 3'd7, "ser_masked");
    drain();
    write_reg(IE_A, 8'h08);
    exp_state(5'b01000, 3'd3, "ser_en");
    drain();

    // 5: event beats same-cycle clear and IF write
    write_reg(IE_A, 8'h1F);
    src = 5'b00100;
    clr = 5'b00100;
    address_bus = IF_A;
    data_bus_in = 8'h00;
    mem_we = 1'b1;
    step();
    src = 5'd0;
    clr = 5'd0;
    mem_we = 1'b0;
    address_bus = 16'h0000;
    exp_if(8'hE4, "ev_wins_if");
    exp_state(5'b00100, 3'd2, "ev_wins");
    drain();
    write_reg(IF_A, 8'h00);
    exp_if(8'hE0, "if_wr0");
    drain();

    // Software-set flags and full-width IE readback
    write_reg(IF_A, 8'h1A);
    exp_if(8'hFA, "sw_set_if");
    exp_state(5'b11010, 3'd1, "sw_set");
    drain();
    write_reg(IE_A, 8'hA5);
    push(K_IE, {1'b1, 8'hA5}, "ie_a5");
    exp_state(5'b00000, 3'd7, "ie_a5");
    drain();
    write_reg(IE_A, 8'h1F);
    write_reg(IF_A, 8'h00);

    // 6: lcd_stat held high for 10 clocks, acknowledged at clock 3
    src = 5'b00010;
    step();
    step();
    clr = 5'b00010;
    step();
    clr = 5'd0;
    for (int k = 4; k <= 10; k++) begin
      step();
`ifdef INT_EDGE_DETECT_EN
      exp_if(8'hE0, $sformatf("lcd_hold_c%0d", k));
`else
      exp_if(8'hE2, $sformatf("lcd_hold_c%0d", k));
`endif
      drain();
    end
    src = 5'd0;
    step();
`ifdef INT_EDGE_DETECT_EN
    exp_if(8'hE0, "lcd_release");
`else
    exp_if(8'hE2, "lcd_release");
`endif
    drain();
    write_reg(IF_A, 8'h00);

    // Async reset mid-operation
    write_reg(IF_A, 8'h1F);
    exp_state(5'b11111, 3'd0, "pre_rst");
    drain();
    #2;
    reset = 1'b1;
    #1;
    exp_if(8'hE0, "async_rst_if");
    push(K_IE, {1'b1, 8'h00}, "async_rst_ie");
    exp_state(5'd0, 3'd7, "async_rst");
    drain();
    step();
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
